// File: rtl/ms108_pkg.sv
// ms108_pkg: definitions shared by the issue-stage scoreboard and its decoder.
//   - 4-bit opcode constants ALU_LW .. ALU_MULI (10..15 are pass-through codes)
//   - bit positions of the opcode/rd/rs/rt fields inside a 32-bit instruction
//   - WB_EN_BIT: write-enable bit of the 6-bit writeback tag
//   - dec_t: decoded register usage of one instruction
package ms108_pkg;

    localparam logic [3:0] ALU_LW    = 4'd0;
    localparam logic [3:0] ALU_SW    = 4'd1;
    localparam logic [3:0] ALU_LI    = 4'd2;
    localparam logic [3:0] ALU_ADDU  = 4'd3;
    localparam logic [3:0] ALU_ADDIU = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_MUL   = 4'd6;
    localparam logic [3:0] ALU_BGE   = 4'd7;
    localparam logic [3:0] ALU_J     = 4'd8;
    localparam logic [3:0] ALU_MULI  = 4'd9;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 28;
    localparam int RD_MSB = 27;
    localparam int RD_LSB = 23;
    localparam int RS_MSB = 22;
    localparam int RS_LSB = 18;
    localparam int RT_MSB = 17;
    localparam int RT_LSB = 13;

    localparam int WB_EN_BIT = 5;

    typedef struct packed {
        logic       use_src1;
        logic [4:0] src1;
        logic       use_src2;
        logic [4:0] src2;
        logic       use_dest;
        logic [4:0] dest;
    } dec_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: bundle of every scoreboard signal except clock and reset.
//   Handshakes (both strict valid/ready): a transfer happens on a rising edge
//   exactly when valid and ready are both high; valid must not depend on ready.
//     decode -> scoreboard : ir_i / ir_valid_i / ir_ready_o
//     scoreboard -> execute: issue_ir_o / issue_valid_o / exec_ready_i
//   Side inputs : wb_num_i (writeback tag), flush_i (discard issue register)
//   Status      : busy_o, stall_cnt_o, spurious_wb_o
//   Modports    : slave = scoreboard side, master = surrounding pipeline.
interface reg_scoreboard_if #(
    parameter int STALL_CNT_W = 16
);
    logic [31:0]            ir_i;
    logic                   ir_valid_i;
    logic                   ir_ready_o;
    logic [31:0]            issue_ir_o;
    logic                   issue_valid_o;
    logic                   exec_ready_i;
    logic [5:0]             wb_num_i;
    logic                   flush_i;
    logic [31:0]            busy_o;
    logic [STALL_CNT_W-1:0] stall_cnt_o;
    logic                   spurious_wb_o;

    modport slave (
        input  ir_i, ir_valid_i, exec_ready_i, wb_num_i, flush_i,
        output ir_ready_o, issue_ir_o, issue_valid_o, busy_o, stall_cnt_o,
               spurious_wb_o
    );

    modport master (
        output ir_i, ir_valid_i, exec_ready_i, wb_num_i, flush_i,
        input  ir_ready_o, issue_ir_o, issue_valid_o, busy_o, stall_cnt_o,
               spurious_wb_o
    );

endinterface

// File: rtl/scb_decode.sv
// scb_decode: combinational decode of an instruction's register usage.
//   ir  : 32-bit instruction
//   dec : {use_src1, src1, use_src2, src2, use_dest, dest}
// src1 is always rs; src2 is rd for stores/branches and rt for reg-reg ALU ops.
module scb_decode
    import ms108_pkg::*;
(
    input  logic [31:0] ir,
    output dec_t        dec
);

    logic [3:0] op;
    assign op = ir[OP_MSB:OP_LSB];

    always_comb begin
        dec          = '0;
        dec.src1     = ir[RS_MSB:RS_LSB];
        dec.dest     = ir[RD_MSB:RD_LSB];
        dec.src2     = ir[RT_MSB:RT_LSB];
        case (op)
            ALU_LW, ALU_ADDIU, ALU_SLL, ALU_MULI: begin
                dec.use_src1 = 1'b1;
                dec.use_dest = 1'b1;
            end
            ALU_SW, ALU_BGE: begin
                dec.use_src1 = 1'b1;
                dec.use_src2 = 1'b1;
                dec.src2     = ir[RD_MSB:RD_LSB];
            end
            ALU_LI: begin
                dec.use_dest = 1'b1;
            end
            ALU_ADDU, ALU_MUL: begin
                dec.use_src1 = 1'b1;
                dec.use_src2 = 1'b1;
                dec.use_dest = 1'b1;
            end
            default: begin
                // J and the pass-through opcodes touch no registers.
            end
        endcase
    end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-stage hazard controller.
//   clk_i   : rising-edge clock
//   rst_n_i : asynchronous active-low reset
//   bus     : reg_scoreboard_if.slave (instruction in, issue out, writeback,
//             flush, busy vector, stall counter, sticky spurious-writeback flag)
// Holds instructions with RAW/WAW hazards against a 32-bit busy vector and
// issues accepted ones through a one-entry register with backpressure.
// Build option: define SCB_WB_BYPASS_EN to let a same-cycle writeback clear
// the busy bit seen by the hazard check (issue one cycle earlier).
module reg_scoreboard
    import ms108_pkg::*;
#(
    parameter int STALL_CNT_W = 16
)
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    reg_scoreboard_if.slave bus
);

    dec_t                   dec;
    logic [31:0]            busy_q;
    logic [31:0]            busy_chk;
    logic [31:0]            busy_next;
    logic [31:0]            issue_ir_q;
    logic                   issue_valid_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic                   spurious_q;
    logic                   wb_en;
    logic [4:0]             wb_reg;
    logic                   hazard;
    logic                   ready;
    logic                   accept;

    scb_decode u_decode (
        .ir  (bus.ir_i),
        .dec (dec)
    );

    assign wb_en  = bus.wb_num_i[WB_EN_BIT];
    assign wb_reg = bus.wb_num_i[4:0];

    // Busy view used only by the hazard check.
    always_comb begin
        busy_chk = busy_q;
`ifdef SCB_WB_BYPASS_EN
        if (wb_en) begin
            busy_chk[wb_reg] = 1'b0;
        end
`endif
    end

    always_comb begin
        hazard = (dec.use_src1 && busy_chk[dec.src1]) ||
                 (dec.use_src2 && busy_chk[dec.src2]) ||
                 (dec.use_dest && busy_chk[dec.dest]);
        ready  = !hazard && !bus.flush_i && (!issue_valid_q || bus.exec_ready_i);
        accept = bus.ir_valid_i && ready;
    end

    // Clear first, then set: an accept marking the register being written
    // back in the same cycle leaves it busy.
    always_comb begin
        busy_next = busy_q;
        if (wb_en) begin
            busy_next[wb_reg] = 1'b0;
        end
        if (accept && dec.use_dest) begin
            busy_next[dec.dest] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q        <= '0;
            issue_ir_q    <= '0;
            issue_valid_q <= 1'b0;
            stall_cnt_q   <= '0;
            spurious_q    <= 1'b0;
        end else begin
            busy_q <= busy_next;
            if (wb_en && !busy_q[wb_reg]) begin
                spurious_q <= 1'b1;
            end
            // accept is already gated by flush_i.
            if (bus.flush_i) begin
                issue_valid_q <= 1'b0;
            end else if (accept) begin
                issue_ir_q    <= bus.ir_i;
                issue_valid_q <= 1'b1;
            end else if (bus.exec_ready_i) begin
                issue_valid_q <= 1'b0;
            end
            if (bus.ir_valid_i && !ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.ir_ready_o    = ready;
    assign bus.issue_ir_o    = issue_ir_q;
    assign bus.issue_valid_o = issue_valid_q;
    assign bus.busy_o        = busy_q;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.spurious_wb_o = spurious_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
    import ms108_pkg::*;

    localparam int SW = 16;

    logic clk;
    logic rst_n;

    reg_scoreboard_if #(.STALL_CNT_W(SW)) bus ();

    reg_scoreboard #(.STALL_CNT_W(SW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [31:0] exp_q[$];
    bit          m_busy[32];
    bit          m_valid;
    bit          m_spur;
    int          m_stalls;
    bit          m_acc;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input int rd, input int rs, input int rt);
        logic [4:0] d, s, t;
        d = 5'(rd);
        s = 5'(rs);
        t = 5'(rt);
        return {op, d, s, t, 13'b0};
    endfunction

    // Register usage per opcode: {reads rs, reads rd, reads rt, writes rd}
    function automatic logic [3:0] usage(input logic [3:0] op);
        case (op)
            ALU_LW, ALU_ADDIU, ALU_SLL, ALU_MULI: return 4'b1001;
            ALU_SW, ALU_BGE:                     return 4'b1100;
            ALU_LI:                              return 4'b0001;
            ALU_ADDU, ALU_MUL:                   return 4'b1011;
            default:                             return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ir_i         = '0;
        bus.ir_valid_i   = 1'b0;
        bus.exec_ready_i = 1'b1;
        bus.wb_num_i     = '0;
        bus.flush_i      = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- model + per-cycle checker ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_valid  = 1'b0;
            m_spur   = 1'b0;
            m_stalls = 0;
            m_acc    = 1'b0;
            exp_q.delete();
        end else begin
            logic [3:0]  u;
            logic [3:0]  op;
            int          rd, rs, rt, wr;
            bit          wb_en, haz, rdy;
            bit          view[32];
            op    = bus.ir_i[31:28];
            rd    = int'(bus.ir_i[27:23]);
            rs    = int'(bus.ir_i[22:18]);
            rt    = int'(bus.ir_i[17:13]);
            wb_en = bus.wb_num_i[5];
            wr    = int'(bus.wb_num_i[4:0]);
            u     = usage(op);
            view  = m_busy;
`ifdef SCB_WB_BYPASS_EN
            if (wb_en) view[wr] = 1'b0;
`endif
            haz = (u[3] && view[rs]) || ((u[2] || u[0]) && view[rd]) || (u[1] && view[rt]);
            rdy = !haz && !bus.flush_i && (!m_valid || bus.exec_ready_i);

            check("ir_ready", 32'(bus.ir_ready_o), 32'(rdy));
            check("issue_valid", 32'(bus.issue_valid_o), 32'(m_valid));
            check("busy", bus.busy_o, busy_vec());
            check("stall_cnt", 32'(bus.stall_cnt_o), (m_stalls > 65535) ? 32'hFFFF : 32'(m_stalls));
            check("spurious_wb", 32'(bus.spurious_wb_o), 32'(m_spur));

            m_acc = bus.ir_valid_i && rdy;
            if (bus.ir_valid_i && !rdy) m_stalls++;
            if (wb_en && !m_busy[wr]) m_spur = 1'b1;
            if (wb_en) m_busy[wr] = 1'b0;
            if (m_acc) begin
                exp_q.push_back(bus.ir_i);
                if (u[0]) m_busy[rd] = 1'b1;
            end
            if (bus.flush_i)           m_valid = 1'b0;
            else if (m_acc)            m_valid = 1'b1;
            else if (bus.exec_ready_i) m_valid = 1'b0;
        end
    end

    // ---------------- monitor: every instruction leaving the issue register ----------------
    always @(negedge clk) begin
        if (rst_n && bus.issue_valid_o && (bus.exec_ready_i || bus.flush_i)) begin
            if (exp_q.size() == 0) begin
                check("issue_unexpected", bus.issue_ir_o, 32'hxxxx_xxxx);
            end else begin
                check("issue_ir", bus.issue_ir_o, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        check("rst_issue_ir", bus.issue_ir_o, 32'h0);
        check("rst_ready", 32'(bus.ir_ready_o), 32'h1);

        // ADDU r3,r1,r2 then ADDIU r4,r3 (RAW on r3), writeback of r3
        bus.ir_i = mk(ALU_ADDU, 3, 1, 2); bus.ir_valid_i = 1'b1;
        step();
        check("addu_busy", bus.busy_o, 32'h0000_0008);
        check("addu_valid", 32'(bus.issue_valid_o), 32'h1);
        bus.ir_i = mk(ALU_ADDIU, 4, 3, 0);
        step();
        step();
        bus.wb_num_i = 6'h23;
        step();
        bus.wb_num_i = 6'h00;
        step();
        bus.ir_valid_i = 1'b0;
        check("raw_busy_after", bus.busy_o, 32'h0000_0010);
        step();

        // WAW on r5
        bus.ir_i = mk(ALU_LI, 5, 0, 0); bus.ir_valid_i = 1'b1;
        step();
        step();
        check("waw_held", 32'(bus.ir_ready_o), 32'h0);
        step();
        bus.wb_num_i = 6'h25;
        step();
        bus.wb_num_i = 6'h00;
        step();
        bus.ir_valid_i = 1'b0;
        check("waw_busy5", 32'(bus.busy_o[5]), 32'h1);
        step();

        // backpressure: LI r8 accepted, LI r9 held 3 cycles
        bus.exec_ready_i = 1'b0;
        bus.ir_i = mk(ALU_LI, 8, 0, 0); bus.ir_valid_i = 1'b1;
        step();
        bus.ir_i = mk(ALU_LI, 9, 0, 0);
        repeat (3) step();
        check("bp_hold_ir", bus.issue_ir_o, mk(ALU_LI, 8, 0, 0));
        bus.exec_ready_i = 1'b1;
        step();
        bus.ir_valid_i = 1'b0;
        check("bp_second", bus.issue_ir_o, mk(ALU_LI, 9, 0, 0));
        step();

        // spurious writeback to idle r7, sticky
        bus.wb_num_i = 6'h27;
        step();
        bus.wb_num_i = 6'h00;
        repeat (3) step();
        check("spurious_sticky", 32'(bus.spurious_wb_o), 32'h1);

        // randomized traffic, fresh state
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int pick;
            bus.ir_valid_i   = ($urandom_range(0, 3) != 0);
            bus.ir_i         = mk(4'($urandom_range(0, 15)), $urandom_range(0, 7),
                                  $urandom_range(0, 7), $urandom_range(0, 7));
            bus.ir_i[12:0]   = 13'($urandom);
            bus.exec_ready_i = ($urandom_range(0, 3) != 0);
            bus.flush_i      = ($urandom_range(0, 15) == 0);
            bus.wb_num_i     = 6'h00;
            if ($urandom_range(0, 2) == 0) begin
                pick = $urandom_range(0, 7);
                for (int k = 0; k < 8; k++) begin
                    if (m_busy[(pick + k) % 8]) begin
                        pick = (pick + k) % 8;
                        break;
                    end
                end
                if ($urandom_range(0, 19) == 0) pick = $urandom_range(0, 31);
                bus.wb_num_i = {1'b1, 5'(pick)};
            end
            step();
        end
        idle_inputs();
        repeat (3) step();

        // saturating stall counter under a permanent RAW hazard on r1
        do_reset();
        bus.ir_i = mk(ALU_LI, 1, 0, 0); bus.ir_valid_i = 1'b1;
        step();
        bus.ir_i = mk(ALU_ADDU, 2, 1, 1);
        repeat (65536 + 5) @(posedge clk);
        #1;
        check("stall_saturated", 32'(bus.stall_cnt_o), 32'hFFFF);

        // asynchronous reset in mid-cycle
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_busy", bus.busy_o, 32'h0);
        check("async_stall", 32'(bus.stall_cnt_o), 32'h0);
        check("async_valid", 32'(bus.issue_valid_o), 32'h0);
        check("async_ir", bus.issue_ir_o, 32'h0);
        check("async_spur", 32'(bus.spurious_wb_o), 32'h0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
